// File: rtl/locker_param.sv
// Multi-channel request/acknowledge locker: captures a set of channels,
// holds them until all captured requests drop, then drains downstream.
module locker_param #(
    parameter int size = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] req_in,
    input  logic [size-1:0] ack_out,
    output logic [size-1:0] req_out,
    output logic [size-1:0] ack_in
);

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        DRAIN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [size-1:0] lock_q;
    logic [size-1:0] lock_d;

    logic ds_ready;
    logic any_req;
    logic held;

    assign ds_ready = (ack_out == '0);
    assign any_req  = (req_in != '0);
    assign held     = ((req_in & lock_q) != '0);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        unique case (state_q)
            IDLE: begin
                if (ds_ready && any_req) begin
                    lock_d  = req_in;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // late requests on unlocked channels wait for a later cycle
                if (!held) begin
                    lock_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ds_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                lock_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // outputs are the lock register itself, so they are glitch-free
    assign req_out = lock_q;
    assign ack_in  = lock_q;

endmodule

// File: tb/tb_locker_param.sv
// Scoreboard bench for locker_param: stimulus queues expected outputs,
// a monitor pops and compares them after each rising edge.
module tb_locker_param;

    localparam int N = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_in;
    logic [N-1:0] ack_out;
    logic [N-1:0] req_out;
    logic [N-1:0] ack_in;

    int total;
    int bad;

    logic [N-1:0] exp_q[$];
    string        tag_q[$];

    locker_param #(.size(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .ack_out(ack_out),
        .req_out(req_out),
        .ack_in (ack_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] e);
        total++;
        if (req_out !== e || ack_in !== e) begin
            bad++;
            $display("FAIL %s: req_out=%b ack_in=%b expected=%b",
                     tag, req_out, ack_in, e);
        end
    endtask

    // monitor: one queued expectation per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic step(input string tag, input logic [N-1:0] r,
                        input logic [N-1:0] a, input logic [N-1:0] e);
        @(negedge clk);
        req_in  = r;
        ack_out = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    initial begin
        int budget;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        req_in  = '0;
        ack_out = '0;
        #3;
        check("reset_async", 2'b00);
        @(posedge clk);
        #2;
        check("reset_hold", 2'b00);
        @(negedge clk);
        rst = 1'b0;

        step("idle_quiet0", 2'b00, 2'b00, 2'b00);
        step("idle_quiet1", 2'b00, 2'b00, 2'b00);

        step("both_capture",  2'b11, 2'b00, 2'b11);
        step("both_ack_hold", 2'b11, 2'b11, 2'b11);
        step("both_release",  2'b00, 2'b11, 2'b00);
        step("both_drain",    2'b00, 2'b11, 2'b00);
        step("both_idle",     2'b00, 2'b00, 2'b00);

        step("ch1_capture", 2'b10, 2'b00, 2'b10);
        step("ch1_release", 2'b00, 2'b10, 2'b00);
        step("ch1_idle",    2'b00, 2'b00, 2'b00);
        step("ch0_capture", 2'b01, 2'b00, 2'b01);
        step("ch0_release", 2'b00, 2'b00, 2'b00);
        step("ch0_idle",    2'b00, 2'b00, 2'b00);

        step("drn_capture",   2'b11, 2'b00, 2'b11);
        step("drn_release",   2'b00, 2'b00, 2'b00);
        step("drn_no_capt",   2'b11, 2'b00, 2'b00);
        step("drn_next_capt", 2'b11, 2'b00, 2'b11);
        step("drn_release2",  2'b00, 2'b00, 2'b00);
        step("drn_idle2",     2'b00, 2'b00, 2'b00);

        step("late_capture", 2'b10, 2'b00, 2'b10);
        step("late_ignored", 2'b11, 2'b00, 2'b10);
        step("late_release", 2'b01, 2'b00, 2'b00);
        step("late_to_idle", 2'b01, 2'b00, 2'b00);
        step("late_served",  2'b01, 2'b00, 2'b01);
        step("late_rel2",    2'b00, 2'b00, 2'b00);
        step("late_idle2",   2'b00, 2'b00, 2'b00);

        step("gate_block0", 2'b11, 2'b01, 2'b00);
        step("gate_block1", 2'b11, 2'b10, 2'b00);
        step("gate_open",   2'b11, 2'b00, 2'b11);

        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_lock", 2'b00);
        step("rst_held_edge", 2'b11, 2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(2'b11);
        tag_q.push_back("rst_resume");
        step("rst_release", 2'b00, 2'b00, 2'b00);
        step("rst_idle",    2'b00, 2'b00, 2'b00);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #3;
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain_queue: pending=%0d required=0",
                     exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
